ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns a stream of received PS/2 set-2 scan-code bytes into key events.
//   A four-state prefix FSM recognises E0 (extended) and F0 (break).
//   Each completed event {ext, rel, code} is pushed into a small FIFO.
//   The arrow keys are tracked as held levels.
//   Bad bytes, prefix sequence errors and prefix timeouts are counted.
//
// Ports
//   CLK, RST      system clock (rising edge); synchronous active-high reset
//   CODE_VALID    one-cycle strobe: CODE holds a received byte
//   CODE          received data byte
//   CODE_ERR      the strobed byte failed its framing/parity check
//   KEY_VALID     the FIFO head holds an event
//   KEY_READY     the consumer takes the head (pop when KEY_VALID && KEY_READY)
//   KEY_CODE      scan code of the head event
//   KEY_EXT       the head event was E0-prefixed
//   KEY_RELEASE   the head event is a break (F0-prefixed)
//   ARROW_STATE   held arrows {RIGHT, LEFT, DOWN, UP}
//   OVERFLOW      sticky: an event was dropped because the FIFO was full
//   ERR_COUNT     saturating count of discarded bytes and sequence errors

module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CODE_VALID,
    input  logic [7:0] CODE,
    input  logic       CODE_ERR,
    output logic       KEY_VALID,
    input  logic       KEY_READY,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_RELEASE,
    output logic [3:0] ARROW_STATE,
    output logic       OVERFLOW,
    output logic [7:0] ERR_COUNT
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW:0]   DEPTH_L = FIFO_DEPTH[PW:0];
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_evt_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          emit;
    logic          err_inc;
    key_evt_t      evt;
    logic          is_prefix;
    logic          is_ignored;

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        emit       = 1'b0;
        err_inc    = 1'b0;
        evt        = '{ext: 1'b0, rel: 1'b0, code: CODE};
        is_prefix  = (CODE == B_E0) || (CODE == B_F0);
        // Keyboard status/reply bytes that carry no key information.
        is_ignored = CODE inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        // A byte arriving on the last counted cycle wins over the timeout.
        tmo_hit    = (state != IDLE) && !CODE_VALID && (tmo_cnt == TMO_LAST);

        if (CODE_VALID) begin
            if (CODE_ERR) begin
                err_inc   = 1'b1;
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (CODE == B_E0)      state_nxt = GOT_E0;
                        else if (CODE == B_F0) state_nxt = GOT_F0;
                        else if (!is_ignored)  emit = 1'b1;
                    end
                    GOT_E0: begin
                        if (CODE == B_F0) begin
                            state_nxt = GOT_E0F0;
                        end else if (CODE != B_E0) begin
                            emit      = 1'b1;
                            evt.ext   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    GOT_F0: begin
                        state_nxt = IDLE;
                        if (is_prefix) begin
                            err_inc = 1'b1;
                        end else begin
                            emit    = 1'b1;
                            evt.rel = 1'b1;
                        end
                    end
                    GOT_E0F0: begin
                        state_nxt = IDLE;
                        if (is_prefix) begin
                            err_inc = 1'b1;
                        end else begin
                            emit    = 1'b1;
                            evt.ext = 1'b1;
                            evt.rel = 1'b1;
                        end
                    end
                endcase
            end
        end else if (tmo_hit) begin
            err_inc   = 1'b1;
            state_nxt = IDLE;
        end
    end

    // The prefix timeout counter only runs while waiting in a prefix state.
    // It restarts on every received byte.
    always_ff @(posedge CLK) begin
        if (RST || CODE_VALID || state == IDLE || tmo_hit) tmo_cnt <= '0;
        else                                              tmo_cnt <= tmo_cnt + TW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST)                                 ERR_COUNT <= 8'h00;
        else if (err_inc && ERR_COUNT != 8'hFF)  ERR_COUNT <= ERR_COUNT + 8'h01;
    end

    // ------------------------------------------------------------------
    // Arrow levels. These are updated from every emitted extended event,
    // even when the FIFO has to drop the event.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            ARROW_STATE <= 4'b0000;
        end else if (emit && evt.ext) begin
            case (evt.code)
                8'h75:   ARROW_STATE[0] <= !evt.rel;  // UP
                8'h72:   ARROW_STATE[1] <= !evt.rel;  // DOWN
                8'h6B:   ARROW_STATE[2] <= !evt.rel;  // LEFT
                8'h74:   ARROW_STATE[3] <= !evt.rel;  // RIGHT
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    key_evt_t   mem [FIFO_DEPTH];
    key_evt_t   head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, pop, push;

    assign full = (count == DEPTH_L);
    assign pop  = KEY_VALID && KEY_READY;
    // When a pop happens in the same cycle, a full FIFO still has room.
    assign push = emit && (!full || pop);

    // The depth is a power of two, so pointer overflow wraps modulo the depth.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
            if (emit && !push) OVERFLOW <= 1'b1;
        end
    end

    // The storage needs no reset. An entry is only visible through the
    // KEY_VALID-gated outputs after it has been written.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= evt;
    end

    assign head        = mem[rd_ptr];
    assign KEY_VALID   = (count != '0);
    assign KEY_CODE    = KEY_VALID ? head.code : 8'h00;
    assign KEY_EXT     = KEY_VALID && head.ext;
    assign KEY_RELEASE = KEY_VALID && head.rel;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CODE_VALID;
    logic [7:0] CODE;
    logic       CODE_ERR;
    logic       KEY_VALID;
    logic       KEY_READY;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT;
    logic       KEY_RELEASE;
    logic [3:0] ARROW_STATE;
    logic       OVERFLOW;
    logic [7:0] ERR_COUNT;

    int total = 0;
    int bad   = 0;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST), .CODE_VALID(CODE_VALID), .CODE(CODE),
        .CODE_ERR(CODE_ERR), .KEY_VALID(KEY_VALID), .KEY_READY(KEY_READY),
        .KEY_CODE(KEY_CODE), .KEY_EXT(KEY_EXT), .KEY_RELEASE(KEY_RELEASE),
        .ARROW_STATE(ARROW_STATE), .OVERFLOW(OVERFLOW), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        CODE = c; CODE_VALID = 1'b1; CODE_ERR = 1'b0;
        tick();
        CODE_VALID = 1'b0;
    endtask

    task automatic send_err(input logic [7:0] c);
        CODE = c; CODE_VALID = 1'b1; CODE_ERR = 1'b1;
        tick();
        CODE_VALID = 1'b0; CODE_ERR = 1'b0;
    endtask

    task automatic pop();
        KEY_READY = 1'b1;
        tick();
        KEY_READY = 1'b0;
    endtask

    task automatic head_pop(input string tag, input logic [7:0] c, input logic x, input logic r);
        chk({tag, ".vld"},  KEY_VALID, 1'b1);
        chk({tag, ".code"}, KEY_CODE, c);
        chk({tag, ".ext"},  KEY_EXT, x);
        chk({tag, ".rel"},  KEY_RELEASE, r);
        pop();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".vld"},  KEY_VALID, 1'b0);
        chk({tag, ".code"}, KEY_CODE, 8'h00);
        chk({tag, ".ext"},  KEY_EXT, 1'b0);
        chk({tag, ".rel"},  KEY_RELEASE, 1'b0);
        chk({tag, ".arw"},  ARROW_STATE, 4'h0);
        chk({tag, ".ovf"},  OVERFLOW, 1'b0);
        chk({tag, ".err"},  ERR_COUNT, 8'h00);
    endtask

    initial begin
        RST = 1'b1; CODE_VALID = 1'b0; CODE = 8'h00; CODE_ERR = 1'b0; KEY_READY = 1'b0;
        tick(); tick();
        RST = 1'b0;
        chk_reset_outs("rst");

        // plain make and break
        send(8'h1C);
        head_pop("make", 8'h1C, 1'b0, 1'b0);
        chk("make.empty", KEY_VALID, 1'b0);
        send(8'hF0); send(8'h1C);
        head_pop("brk", 8'h1C, 1'b0, 1'b1);

        // extended arrows
        send(8'hE0); send(8'h75);
        chk("up.arw", ARROW_STATE, 4'b0001);
        head_pop("up", 8'h75, 1'b1, 1'b0);
        send(8'hE0); send(8'h6B);
        chk("left.arw", ARROW_STATE, 4'b0101);
        pop();
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("upbrk.arw", ARROW_STATE, 4'b0100);
        head_pop("upbrk", 8'h75, 1'b1, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("leftbrk.arw", ARROW_STATE, 4'b0000);
        pop();
        send(8'h75);                  // keypad 8: not an arrow
        chk("kp.arw", ARROW_STATE, 4'b0000);
        head_pop("kp", 8'h75, 1'b0, 1'b0);

        // status bytes are ignored without counting
        send(8'hAA); send(8'hFA);
        chk("ign.vld", KEY_VALID, 1'b0);
        chk("ign.err", ERR_COUNT, 8'h00);

        // FIFO fill, overflow, then push+pop while full
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("full.ovf", OVERFLOW, 1'b0);
        send(8'h55);
        chk("drop.ovf", OVERFLOW, 1'b1);
        chk("drop.head", KEY_CODE, 8'h11);
        CODE = 8'h66; CODE_VALID = 1'b1; KEY_READY = 1'b1;
        tick();
        CODE_VALID = 1'b0; KEY_READY = 1'b0;
        head_pop("q1", 8'h22, 1'b0, 1'b0);
        head_pop("q2", 8'h33, 1'b0, 1'b0);
        head_pop("q3", 8'h44, 1'b0, 1'b0);
        head_pop("q4", 8'h66, 1'b0, 1'b0);
        chk("q.empty", KEY_VALID, 1'b0);

        // push+pop with a single entry
        send(8'h77);
        CODE = 8'h78; CODE_VALID = 1'b1; KEY_READY = 1'b1;
        tick();
        CODE_VALID = 1'b0; KEY_READY = 1'b0;
        head_pop("one", 8'h78, 1'b0, 1'b0);
        chk("one.empty", KEY_VALID, 1'b0);

        // prefix timeout
        chk("tmo.err0", ERR_COUNT, 8'h00);
        send(8'hE0);
        repeat (TMO + 5) tick();
        chk("tmo.err", ERR_COUNT, 8'h01);
        send(8'h1C);
        head_pop("tmo.key", 8'h1C, 1'b0, 1'b0);

        // sequence error F0,F0
        send(8'hF0); send(8'hF0);
        chk("seq.err", ERR_COUNT, 8'h02);
        chk("seq.vld", KEY_VALID, 1'b0);

        // corrupted byte mid-sequence
        send(8'hE0); send_err(8'hF0);
        chk("cerr.err", ERR_COUNT, 8'h03);
        chk("cerr.vld", KEY_VALID, 1'b0);
        send(8'h1C);
        head_pop("cerr.key", 8'h1C, 1'b0, 1'b0);

        // saturation
        for (int i = 0; i < 250; i++) send_err(8'h5A);
        chk("sat.mid", ERR_COUNT, 8'd253);
        for (int i = 0; i < 50; i++) send_err(8'h5A);
        chk("sat.end", ERR_COUNT, 8'd255);
        chk("sat.vld", KEY_VALID, 1'b0);

        // reset with a partial prefix and queued events
        send(8'hE0); send(8'h74);
        send(8'h22);
        send(8'hE0); send(8'hF0);
        chk("pre.arw", ARROW_STATE, 4'b1000);
        chk("pre.vld", KEY_VALID, 1'b1);
        RST = 1'b1; CODE = 8'h33; CODE_VALID = 1'b1; KEY_READY = 1'b1;
        tick();
        RST = 1'b0; CODE_VALID = 1'b0; KEY_READY = 1'b0;
        chk_reset_outs("rst2");
        send(8'h29);
        head_pop("post", 8'h29, 1'b0, 1'b0);
        chk("post.empty", KEY_VALID, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
